change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser.sv | 137 +++++++++++++
 tb/tb_change_dispenser.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Greedy change dispenser: ejects one coin per cycle, largest denomination that still fits first.
// Define CHANGE_INVENTORY_EN to add per-coin stock counters with refill; otherwise supply is unlimited.
module change_dispenser #(
   parameter int kNumCoins   = 3,
   parameter int kTotalBits  = 31,
   parameter int COIN0_VALUE = 100,
   parameter int COIN1_VALUE = 500,
   parameter int COIN2_VALUE = 1000,
   parameter int kStockBits  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_start,
   input  logic [kTotalBits-1:0] i_total,
   input  logic                  i_refill,
   input  logic [kNumCoins-1:0]  i_refill_coin,
   output logic [kNumCoins-1:0]  o_return_coin,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_short,
   output logic [kTotalBits-1:0] o_remaining
);

   typedef enum logic [1:0] {IDLE, DISPENSE, DONE} state_t;

   localparam logic [kTotalBits-1:0] kCoinValue [3] = '{
      kTotalBits'(COIN0_VALUE), kTotalBits'(COIN1_VALUE), kTotalBits'(COIN2_VALUE)};

   state_t                state;
   state_t                state_next;
   logic [kNumCoins-1:0]  in_stock;
   logic [kNumCoins-1:0]  pick;
   logic                  found;
   logic [kTotalBits-1:0] pick_value;

   // Values ascend with index, so the last eligible coin seen in the scan is the largest one.
   always_comb begin
      pick       = '0;
      found      = 1'b0;
      pick_value = '0;
      for (int i = 0; i < kNumCoins; i++) begin
         if (in_stock[i] && (o_remaining != '0) && (kCoinValue[i] <= o_remaining)) begin
            pick       = '0;
            pick[i]    = 1'b1;
            found      = 1'b1;
            pick_value = kCoinValue[i];
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (i_start) state_next = DISPENSE;
         DISPENSE: if (!found) state_next = DONE;
         DONE:     state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   // The subtraction only happens when a coin fits, so the remaining amount cannot wrap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         o_return_coin <= '0;
         o_busy        <= 1'b0;
         o_done        <= 1'b0;
         o_short       <= 1'b0;
         o_remaining   <= '0;
      end else begin
         state         <= state_next;
         o_done        <= 1'b0;
         o_return_coin <= '0;
         case (state)
            IDLE: begin
               if (i_start) begin
                  o_remaining <= i_total;
                  o_short     <= 1'b0;
                  o_busy      <= 1'b1;
               end
            end
            DISPENSE: begin
               if (found) begin
                  o_return_coin <= pick;
                  o_remaining   <= o_remaining - pick_value;
               end else begin
                  o_busy  <= 1'b0;
                  o_done  <= 1'b1;
                  o_short <= (o_remaining != '0);
               end
            end
            default: ;
         endcase
      end
   end

`ifdef CHANGE_INVENTORY_EN
   localparam logic [kStockBits-1:0] kStockMax = '1;

   logic [kStockBits-1:0] stock [kNumCoins];
   logic [kNumCoins-1:0]  refill_hit;
   logic [kNumCoins-1:0]  eject_hit;

   assign refill_hit = i_refill ? i_refill_coin : '0;
   assign eject_hit  = (state == DISPENSE) ? pick : '0;

   always_comb begin
      in_stock = '0;
      for (int i = 0; i < kNumCoins; i++) begin
         in_stock[i] = (stock[i] != '0);
      end
   end

   // A refill and an ejection of the same coin cancel out.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < kNumCoins; i++) begin
            stock[i] <= '0;
         end
      end else begin
         for (int i = 0; i < kNumCoins; i++) begin
            if (refill_hit[i] && !eject_hit[i]) begin
               if (stock[i] != kStockMax) stock[i] <= stock[i] + 1'b1;
            end else if (eject_hit[i] && !refill_hit[i]) begin
               stock[i] <= stock[i] - 1'b1;
            end
         end
      end
   end
`else
   logic unused_refill;

   assign in_stock      = '1;
   assign unused_refill = ^{i_refill, i_refill_coin};
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: table of return amounts, coin scoreboard, corner sequences.
// Build with CHANGE_INVENTORY_EN defined to exercise the stock-tracking variant.
module tb_change_dispenser;

   localparam int kNumCoins  = 3;
   localparam int kTotalBits = 31;
   localparam int kStockBits = 8;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  i_start;
   logic [kTotalBits-1:0] i_total;
   logic                  i_refill;
   logic [kNumCoins-1:0]  i_refill_coin;
   logic [kNumCoins-1:0]  o_return_coin;
   logic                  o_busy;
   logic                  o_done;
   logic                  o_short;
   logic [kTotalBits-1:0] o_remaining;

   always #5 clk = ~clk;

   change_dispenser #(
      .kNumCoins  (kNumCoins),
      .kTotalBits (kTotalBits),
      .COIN0_VALUE(100),
      .COIN1_VALUE(500),
      .COIN2_VALUE(1000),
      .kStockBits (kStockBits)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .i_start      (i_start),
      .i_total      (i_total),
      .i_refill     (i_refill),
      .i_refill_coin(i_refill_coin),
      .o_return_coin(o_return_coin),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_short      (o_short),
      .o_remaining  (o_remaining)
   );

   typedef struct {
      string name;
      int    total;
      int    ncoins;
      bit    exp_short;
      int    exp_rem;
   } vec_t;

   int                   checks = 0;
   int                   failures = 0;
   logic [kNumCoins-1:0] exp_q[$];
   int                   model_stock[3] = '{0, 0, 0};
   int                   coin_val[3] = '{100, 500, 1000};
   vec_t                 vecs[6];

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
      end
   endtask

   // Greedy reference: pushes the expected coin sequence and updates the model stock.
   task automatic modelPush(input int total, input bit refill_eject);
      int rem;
      int idx;
      bit first;
      bit going;
      rem   = total;
      first = 1'b1;
      going = 1'b1;
      while (going) begin
         idx = -1;
         for (int i = 0; i < 3; i++) begin
`ifdef CHANGE_INVENTORY_EN
            if (rem > 0 && coin_val[i] <= rem && model_stock[i] > 0) idx = i;
`else
            if (rem > 0 && coin_val[i] <= rem) idx = i;
`endif
         end
         if (idx < 0) begin
            going = 1'b0;
         end else begin
            exp_q.push_back(3'(1 << idx));
            rem -= coin_val[idx];
`ifdef CHANGE_INVENTORY_EN
            if (first && refill_eject) begin
               if (idx != 0) begin
                  if (model_stock[0] < 255) model_stock[0]++;
                  model_stock[idx]--;
               end
            end else begin
               model_stock[idx]--;
            end
`endif
            first = 1'b0;
         end
      end
   endtask

   task automatic refillCoin(input logic [2:0] coin, input int count);
      repeat (count) begin
         @(negedge clk);
         i_refill      = 1'b1;
         i_refill_coin = coin;
         for (int i = 0; i < 3; i++) begin
            if (coin[i] && model_stock[i] < 255) model_stock[i]++;
         end
      end
      @(negedge clk);
      i_refill      = 1'b0;
      i_refill_coin = '0;
   endtask

   task automatic doReset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 3; i++) model_stock[i] = 0;
   endtask

   // One full return; optional restart pulse mid-dispense, refill during first ejection, hold check.
   task automatic applyStimulus(input string name, input int total, input int exp_n,
                                input bit exp_short, input int exp_rem, input bit restart,
                                input bit refill_eject, input bit hold_check);
      int cycles;
      bit seen_done;
      @(negedge clk);
      exp_q.delete();
      modelPush(total, refill_eject);
      i_total = kTotalBits'(total);
      i_start = 1'b1;
      cycles    = 0;
      seen_done = 1'b0;
      while (!seen_done && cycles < 40) begin
         @(negedge clk);
         cycles++;
         if (cycles == 1) begin
            i_start = 1'b0;
            i_total = kTotalBits'(12345);
            checkOutput({name, "_busy"}, o_busy, 1);
            if (refill_eject) begin
               i_refill      = 1'b1;
               i_refill_coin = 3'b001;
            end
         end else if (cycles == 2) begin
            i_refill      = 1'b0;
            i_refill_coin = '0;
            if (restart) begin
               i_start = 1'b1;
               i_total = kTotalBits'(50);
            end
         end else if (cycles == 3) begin
            i_start = 1'b0;
         end
         if (o_return_coin != '0) begin
            if (exp_q.size() == 0) checkOutput({name, "_extra_coin"}, o_return_coin, 0);
            else checkOutput({name, "_coin"}, o_return_coin, exp_q.pop_front());
         end
         if (o_done) begin
            seen_done = 1'b1;
            checkOutput({name, "_latency"}, cycles, exp_n + 2);
            checkOutput({name, "_short"}, o_short, exp_short);
            checkOutput({name, "_remaining"}, o_remaining, exp_rem);
            checkOutput({name, "_coins_left"}, exp_q.size(), 0);
            checkOutput({name, "_busy_end"}, o_busy, 0);
         end
      end
      if (!seen_done) checkOutput({name, "_done_timeout"}, 0, 1);
      @(negedge clk);
      checkOutput({name, "_done_pulse"}, o_done, 0);
      if (hold_check) begin
         repeat (3) @(negedge clk);
         checkOutput({name, "_hold_short"}, o_short, exp_short);
         checkOutput({name, "_hold_remaining"}, o_remaining, exp_rem);
      end
   endtask

   task automatic resetMidDispense(input int total);
      bit seen;
      @(negedge clk);
      i_total = kTotalBits'(total);
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      @(negedge clk);
      checkOutput("pre_abort_busy", o_busy, 1);
      checkOutput("pre_abort_coin", (o_return_coin != '0), 1);
      #2 reset = 1'b1;
      #1;
      checkOutput("abort_coin", o_return_coin, 0);
      checkOutput("abort_busy", o_busy, 0);
      checkOutput("abort_done", o_done, 0);
      checkOutput("abort_short", o_short, 0);
      checkOutput("abort_remaining", o_remaining, 0);
      @(negedge clk);
      reset = 1'b0;
      seen  = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (o_done || o_busy) seen = 1'b1;
      end
      checkOutput("abort_no_done", seen, 0);
      exp_q.delete();
      for (int i = 0; i < 3; i++) model_stock[i] = 0;
   endtask

`ifdef CHANGE_INVENTORY_EN
   task automatic checkStock(input string name, input int s0, input int s1, input int s2);
      checkOutput({name, "_stock100"}, dut.stock[0], s0);
      checkOutput({name, "_stock500"}, dut.stock[1], s1);
      checkOutput({name, "_stock1000"}, dut.stock[2], s2);
   endtask
`endif

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: got 0, want 1");
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin
      reset         = 1'b1;
      i_start       = 1'b0;
      i_total       = '0;
      i_refill      = 1'b0;
      i_refill_coin = '0;
      #1;
      checkOutput("reset_coin", o_return_coin, 0);
      checkOutput("reset_busy", o_busy, 0);
      checkOutput("reset_done", o_done, 0);
      checkOutput("reset_short", o_short, 0);
      checkOutput("reset_remaining", o_remaining, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

`ifdef CHANGE_INVENTORY_EN
      checkStock("reset", 0, 0, 0);
      refillCoin(3'b001, 5);
      refillCoin(3'b010, 1);
      refillCoin(3'b100, 1);
      applyStimulus("restart_ignored", 1700, 4, 1'b0, 0, 1'b1, 1'b0, 1'b0);
      checkStock("after_1700", 3, 0, 0);
      resetMidDispense(300);
      checkStock("after_abort", 0, 0, 0);

      refillCoin(3'b001, 5);
      refillCoin(3'b100, 1);
      applyStimulus("stock_1300", 1300, 4, 1'b0, 0, 1'b0, 1'b0, 1'b1);
      checkStock("after_1300", 2, 0, 0);

      doReset();
      refillCoin(3'b001, 1);
      applyStimulus("stock_short_300", 300, 1, 1'b1, 200, 1'b0, 1'b0, 1'b1);
      checkStock("after_300", 0, 0, 0);

      refillCoin(3'b001, 260);
      checkStock("saturate", 255, 0, 0);
      applyStimulus("refill_and_eject", 100, 1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
      checkStock("after_refill_eject", 255, 0, 0);
      applyStimulus("plain_eject", 100, 1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      checkStock("after_plain_eject", 254, 0, 0);
`else
      vecs[0] = '{"ret_1700", 1700, 4, 1'b0, 0};
      vecs[1] = '{"ret_50",   50,   0, 1'b1, 50};
      vecs[2] = '{"ret_0",    0,    0, 1'b0, 0};
      vecs[3] = '{"ret_2350", 2350, 5, 1'b1, 50};
      vecs[4] = '{"ret_600",  600,  2, 1'b0, 0};
      vecs[5] = '{"ret_1000", 1000, 1, 1'b0, 0};
      for (int v = 0; v < 6; v++) begin
         applyStimulus(vecs[v].name, vecs[v].total, vecs[v].ncoins, vecs[v].exp_short,
                       vecs[v].exp_rem, 1'b0, 1'b0, (v == 1));
      end
      applyStimulus("restart_ignored", 1700, 4, 1'b0, 0, 1'b1, 1'b0, 1'b0);
      applyStimulus("refill_ignored", 1600, 3, 1'b0, 0, 1'b0, 1'b1, 1'b0);
      resetMidDispense(1700);
      applyStimulus("after_abort", 700, 3, 1'b0, 0, 1'b0, 1'b0, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
